// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and MEM-stage requests onto one single-port memory,
// registering the winner and steering read data back through a tag pipeline.
module mem_port_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ifReq,
    input  logic [31:0] i_ifAddr,
    output logic        o_ifGnt,
    output logic        o_ifRvalid,
    output logic [31:0] o_ifRdata,
    input  logic        i_dReq,
    input  logic        i_dWe,
    input  logic [31:0] i_dAddr,
    input  logic [31:0] i_dWdata,
    input  logic [3:0]  i_dBe,
    output logic        o_dGnt,
    output logic        o_dRvalid,
    output logic [31:0] o_dRdata,
    output logic        o_memEn,
    output logic        o_memWe,
    output logic [31:0] o_memAddr,
    output logic [31:0] o_memWdata,
    output logic [3:0]  o_memBe,
    input  logic [31:0] i_memRdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Handshake: a requester raises req with stable fields and holds them until
    // its gnt is seen high in the same cycle; the access is taken at that edge,
    // and the requester may present a new request in the very next cycle.
    logic [3:0]            starve_cnt;
    logic                  mem_owner;   // 1 = data requester owns the issued access
    logic [RD_LATENCY-1:0] tag_valid;
    logic [RD_LATENCY-1:0] tag_owner;
    logic [31:0]           if_rdata_q;
    logic [31:0]           d_rdata_q;
    logic                  resp_if;
    logic                  resp_d;

    assign o_ifGnt = i_ifReq & (~i_dReq | (starve_cnt == STARVE_LIM));
    assign o_dGnt  = i_dReq & ~o_ifGnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt <= 4'd0;
        end else if (i_ifReq && !o_ifGnt) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // Address, write data and byte enables keep their last values on idle cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_memEn    <= 1'b0;
            o_memWe    <= 1'b0;
            o_memAddr  <= 32'd0;
            o_memWdata <= 32'd0;
            o_memBe    <= 4'd0;
            mem_owner  <= 1'b0;
        end else begin
            o_memEn <= o_ifGnt | o_dGnt;
            o_memWe <= o_dGnt & i_dWe;
            if (o_ifGnt) begin
                o_memAddr <= i_ifAddr;
                o_memBe   <= 4'hF;
                mem_owner <= 1'b0;
            end else if (o_dGnt) begin
                o_memAddr  <= i_dAddr;
                o_memWdata <= i_dWdata;
                o_memBe    <= i_dBe;
                mem_owner  <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid[0] <= o_memEn & ~o_memWe;
            tag_owner[0] <= mem_owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    assign resp_if = tag_valid[RD_LATENCY-1] & ~tag_owner[RD_LATENCY-1];
    assign resp_d  = tag_valid[RD_LATENCY-1] &  tag_owner[RD_LATENCY-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            if (resp_if) if_rdata_q <= i_memRdata;
            if (resp_d)  d_rdata_q  <= i_memRdata;
        end
    end

    // Response data is passed through in its valid cycle and held afterwards.
    assign o_ifRvalid = resp_if;
    assign o_dRvalid  = resp_d;
    assign o_ifRdata  = resp_if ? i_memRdata : if_rdata_q;
    assign o_dRdata   = resp_d  ? i_memRdata : d_rdata_q;

    if_req_hold: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (i_ifReq && !o_ifGnt) |=> (i_ifReq && $stable(i_ifAddr)));

    d_req_hold: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (i_dReq && !o_dGnt) |=> (i_dReq && $stable(i_dWe) && $stable(i_dAddr)
                                 && $stable(i_dWdata) && $stable(i_dBe)));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Arbitrates on each cycle and registers the winning request onto the memory port.
- Tracks in-flight reads through a tag pipeline and returns read data to the requester that issued them.
- Sits between the fetch/MEM stage logic and mem_memory. Data requests have priority, and a starvation counter bounds how long fetch can be held off.

Parameters:
- RD_LATENCY, 1: cycles from o_memEn (read) asserted to i_memRdata valid; legal range 1..4.
- STARVE_MAX, 4: consecutive IF-denied cycles after which IF wins the next contention; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_ifReq  in  1  IF read request; held until o_ifGnt
- i_ifAddr  in  32  IF read address
- o_ifGnt  out  1  IF request accepted this cycle (combinational)
- o_ifRvalid  out  1  IF read data valid
- o_ifRdata  out  32  IF read data
- i_dReq  in  1  data request; held until o_dGnt
- i_dWe  in  1  1 = store, 0 = load
- i_dAddr  in  32  data address
- i_dWdata  in  32  store data
- i_dBe  in  4  byte enables for stores
- o_dGnt  out  1  data request accepted this cycle (combinational)
- o_dRvalid  out  1  load data valid
- o_dRdata  out  32  load data
- o_memEn  out  1  memory access strobe (registered)
- o_memWe  out  1  memory write enable (registered)
- o_memAddr  out  32  memory address (registered)
- o_memWdata  out  32  memory write data (registered)
- o_memBe  out  4  memory byte enables (registered)
- i_memRdata  in  32  memory read data, valid RD_LATENCY cycles after a read strobe

Behaviour:
- Reset:
  - All registered outputs are 0, starvation counter is 0, tag pipeline is cleared.
  - o_ifRvalid and o_dRvalid are 0.
  - o_ifRdata and o_dRdata are 0.
- Arbitration (combinational, each cycle; at most one grant per cycle):
  - Only one requester active: it is granted.
  - Both active and starve_cnt < STARVE_MAX: data is granted.
  - Both active and starve_cnt == STARVE_MAX: IF is granted.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on cycles with i_ifReq=1 and o_ifGnt=0.
  - Clears to 0 on o_ifGnt=1 or i_ifReq=0.
- Issue:
  - On the clock edge after a grant, o_memEn=1 and o_mem* carry the granted request's fields.
  - An IF grant forces o_memWe=0 and o_memBe=4'hF.
  - A cycle with no grant produces o_memEn=0. o_memAddr, o_memWdata and o_memBe then hold their previous values; o_memWe=0.
  - Back-to-back grants issue on consecutive cycles, giving full throughput of one access per cycle.
- Tag pipeline:
  - A RD_LATENCY-deep shift register of {valid, owner}, pushed each cycle with {o_memEn & ~o_memWe, owner}.
  - At the output stage, valid=1 asserts the owner's Rvalid for exactly one cycle, with Rdata = i_memRdata.
  - The non-owner's Rdata holds its last value.
- Latency:
  - A read granted at cycle N has o_memEn at N+1 and Rvalid at N+1+RD_LATENCY.
  - Stores produce no Rvalid.
- Ordering: responses return in issue order. Per-requester ordering is preserved; no reordering logic.
- Protocol:
  - A requester must hold its req and fields stable until granted.
  - A field change while req=1 and ungranted is illegal and is covered by assertion.
  - A requester may re-request in the cycle after its grant.
- Reset mid-operation: in-flight reads are discarded. No Rvalid is asserted after i_reset_n deasserts for reads issued before reset.
- Simultaneous grant and response in the same cycle are independent; both proceed.

Test Plan:
1. Single IF read:
   - Stimulus: RD_LATENCY=1, i_ifReq with addr 0x100 at cycle 0, memory returns 0xDEADBEEF.
   - Required: o_ifGnt=1 at cycle 0; o_memEn=1, o_memWe=0, o_memAddr=0x100 at cycle 1; o_ifRvalid=1 with 0xDEADBEEF at cycle 2.
2. Data store:
   - Stimulus: i_dReq, i_dWe=1, addr 0x20, wdata 0x12345678, be 4'b0011.
   - Required: memory strobe with those exact fields one cycle after o_dGnt; no o_dRvalid ever.
3. Contention and starvation, STARVE_MAX=4:
   - Stimulus: both requests held continuously.
   - Required: data granted 4 cycles; cycle 5 grants IF; counter is 0 afterwards; the pattern repeats 4:1.
4. Interleaved reads, RD_LATENCY=2:
   - Stimulus: grants D(0x40), IF(0x80), D(0x44) on cycles 0, 1, 2.
   - Required: o_dRvalid at 3, o_ifRvalid at 4, o_dRvalid at 5, each with the matching memory data.
5. Reset mid-flight:
   - Stimulus: assert i_reset_n=0 one cycle after a read issue, release 2 cycles later.
   - Required: all outputs 0 during reset; no Rvalid after release.
6. Idle hold:
   - Stimulus: no requests for 3 cycles after a store to 0x20.
   - Required: o_memEn=0 and o_memWe=0 throughout; o_memAddr stays 0x20; starve_cnt=0.
